// File: rtl/div_sequencer.sv
// Iterative restoring radix-2 divider for RV32M DIV/DIVU/REM/REMU.
// Stalls Execute while computing and pulses div_done_o for one cycle with the result.
module div_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  input  logic             div_start_e_i,
  input  logic [2:0]       funct3_e_i,
  input  logic [WIDTH-1:0] op_a_e_i,
  input  logic [WIDTH-1:0] op_b_e_i,
  input  logic             flush_e_i,
  output logic             stall_o,
  output logic             div_done_o,
  output logic [WIDTH-1:0] div_result_o
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;

  state_e           r_state;
  state_e           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH-1:0] r_result;
  logic             r_sel_rem;
  logic             r_neg_q;
  logic             r_neg_r;

  logic             w_accept;
  logic             w_signed;
  logic             w_special;
  logic             w_stall;
  logic [WIDTH-1:0] w_abs_a;
  logic [WIDTH-1:0] w_abs_b;
  logic [WIDTH-1:0] w_special_res;
  logic [WIDTH:0]   w_rem_sh;
  logic [WIDTH:0]   w_diff;
  logic             w_borrow;
  logic [WIDTH-1:0] w_rem_step;
  logic [WIDTH-1:0] w_quo_step;
  logic [WIDTH-1:0] w_fin;

  // funct3[2] is set for every M-extension divide encoding, so it qualifies start.
  assign w_accept  = div_start_e_i & ~flush_e_i & funct3_e_i[2];
  assign w_signed  = ~funct3_e_i[0];
  assign w_abs_a   = (w_signed && op_a_e_i[WIDTH-1]) ? -op_a_e_i : op_a_e_i;
  assign w_abs_b   = (w_signed && op_b_e_i[WIDTH-1]) ? -op_b_e_i : op_b_e_i;
  assign w_special = (op_b_e_i == '0) ||
                     (w_signed && op_a_e_i == MIN_VAL && op_b_e_i == '1);
  assign w_special_res = (op_b_e_i == '0) ? (funct3_e_i[1] ? op_a_e_i : '1)
                                          : (funct3_e_i[1] ? '0 : MIN_VAL);

  // The partial remainder needs one extra bit before the trial subtract.
  assign w_rem_sh   = {r_rem, r_quo[WIDTH-1]};
  assign w_diff     = w_rem_sh - {1'b0, r_div};
  assign w_borrow   = w_diff[WIDTH];
  assign w_rem_step = w_borrow ? w_rem_sh[WIDTH-1:0] : w_diff[WIDTH-1:0];
  assign w_quo_step = {r_quo[WIDTH-2:0], ~w_borrow};
  assign w_fin      = r_sel_rem ? (r_neg_r ? -w_rem_step : w_rem_step)
                                : (r_neg_q ? -w_quo_step : w_quo_step);

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    div_done_o  = 1'b0;
    case (r_state)
      IDLE: begin
        w_stall = w_accept;
        if (w_accept) w_state_nxt = w_special ? DONE : CALC;
      end
      CALC: begin
        if (flush_e_i) begin
          w_state_nxt = IDLE;
        end else begin
          w_stall = 1'b1;
          if (r_cnt == '0) w_state_nxt = DONE;
        end
      end
      DONE: begin
        div_done_o  = ~flush_e_i;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign stall_o      = w_stall & reset_n_i;
  assign div_result_o = r_result;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_div     <= '0;
      r_result  <= '0;
      r_sel_rem <= 1'b0;
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_sel_rem <= funct3_e_i[1];
            r_neg_q   <= w_signed & (op_a_e_i[WIDTH-1] ^ op_b_e_i[WIDTH-1]);
            r_neg_r   <= w_signed & op_a_e_i[WIDTH-1];
            r_quo     <= w_abs_a;
            r_div     <= w_abs_b;
            r_rem     <= '0;
            r_cnt     <= CW'(WIDTH - 1);
            if (w_special) r_result <= w_special_res;
          end
        end
        CALC: begin
          if (!flush_e_i) begin
            r_quo <= w_quo_step;
            r_rem <= w_rem_step;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == '0) r_result <= w_fin;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/div_sequencer.md
Name: div_sequencer

Overview:
- Iterative divide controller and datapath for the RV32M DIV/DIVU/REM/REMU instructions, sitting in the Execute stage beside the ALU.
- It accepts a decoded divide op from the Execute stage and runs a restoring radix-2 divider for WIDTH cycles.
- While busy it holds the pipeline via a stall request to the hazard unit.
- It presents a one-cycle result for the writeback path.

Parameters:
- WIDTH, 32, operand/result width in bits; counter width is clog2(WIDTH).

Ports:
- clk_i  in  1  system clock; all state updates on the rising edge.
- reset_n_i  in  1  asynchronous, active-low reset.
- div_start_e_i  in  1  a divide instruction is valid in Execute; held high until the instruction leaves Execute.
- funct3_e_i  in  3  100=DIV, 101=DIVU, 110=REM, 111=REMU.
- op_a_e_i  in  WIDTH  dividend (rs1).
- op_b_e_i  in  WIDTH  divisor (rs2).
- flush_e_i  in  1  Execute flush from the hazard unit.
- stall_o  out  1  stall request; freezes F/D/E.
- div_done_o  out  1  result valid this cycle; single-cycle pulse.
- div_result_o  out  WIDTH  quotient or remainder.

Behaviour:
- Reset (asynchronous, reset_n_i=0):
  - state=IDLE; counter, internal registers, div_result_o all 0.
  - div_done_o=0; stall_o forced 0 while in reset.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - stall_o = div_start_e_i & ~flush_e_i (combinational).
  - On start & ~flush:
    - Latch funct3.
    - Signed ops (funct3[0]=0): store |a| and |b|; record neg_q = sign(a)^sign(b) and neg_r = sign(a).
    - Unsigned ops: store raw operands; neg_q = neg_r = 0.
    - Clear the remainder register; counter = WIDTH-1.
  - Next state:
    - b==0, or (signed & a==MIN & b==-1): DONE, with the special result preloaded.
    - Otherwise: CALC.
- CALC:
  - stall_o=1.
  - Each cycle one restoring step: shift {rem, quo} left by 1, trial subtract b, set the quotient LSB if no borrow.
  - Counter decrements; on the counter==0 cycle the next state is DONE.
  - Exactly WIDTH CALC cycles.
- DONE:
  - stall_o=0, div_done_o=1.
  - div_result_o = quotient (funct3[1]=0) or remainder (funct3[1]=1), negated when neg_q / neg_r applies.
  - Next state IDLE unconditionally.
  - div_start_e_i is ignored in DONE: it is the same instruction advancing.
- Latency:
  - Normal op: start cycle + WIDTH CALC cycles = WIDTH+1 stall cycles; result on cycle WIDTH+1 after start (33 for WIDTH=32).
  - Special cases: 1 stall cycle; result on cycle 1.
- Special results (per RISC-V spec):
  - Divide by zero: quotient = all ones; remainder = dividend.
  - Signed overflow (MIN / -1): quotient = MIN; remainder = 0.
  - No sign correction is applied to these.
- div_result_o holds its last value outside DONE; consumers qualify with div_done_o.
- Back-to-back divides: a new start is accepted in the IDLE cycle immediately after DONE.
- flush_e_i asserted in CALC or DONE:
  - Next state IDLE; div_done_o=0 that cycle; stall_o=0 in the flush cycle.
  - No result is produced.
- flush_e_i with start in IDLE: the op is not accepted.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0; no residual done pulse after release.
- Signals not used for the current op are don't-care: funct3_e_i after the start cycle, and operands after latch.

Test Plan:
- DIV a=100, b=7: stall_o high 33 cycles; div_done_o pulses on cycle 33; div_result_o=14; stall_o=0 in the done cycle.
- REM a=-7 (0xFFFFFFF9), b=2 → 0xFFFFFFFF (-1). DIV a=-7, b=2 → 0xFFFFFFFD (-3). DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC.
- DIVU a=0x1234, b=0: 1 stall cycle; done on cycle 1; result 0xFFFFFFFF. REMU same operands → 0x00001234.
- DIV 0x80000000 / 0xFFFFFFFF → 0x80000000 after 1 stall cycle. REM same operands → 0x00000000.
- DIV 100/7 with flush_e_i pulsed on CALC cycle 10: stall_o drops that cycle; no div_done_o ever. A following DIVU 9/3 started next cycle → 3, with correct 33-cycle latency.
- reset_n_i pulled low on CALC cycle 5 of DIV 100/7: outputs immediately 0, state IDLE. After release with start held high, a fresh op runs the full 33 cycles → 14.
